// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: entry FSM states, operand
// widths and the bit layout of the adder switch bus {cin, A, B}.
package operand_sequencer_pkg;

    localparam int unsigned OPERAND_W = 4;
    localparam int unsigned BUS_W     = 9;

    localparam int unsigned CIN_BIT = 8;
    localparam int unsigned A_MSB   = 7;
    localparam int unsigned A_LSB   = 4;
    localparam int unsigned B_MSB   = 3;
    localparam int unsigned B_LSB   = 0;

    // Encoding is exposed directly on the phase LEDs.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        READY  = 2'd3
    } state_e;

endpackage

// File: rtl/operand_sequencer_key_debouncer.sv
// key_debouncer: two-flop synchroniser, debounce counter and press-pulse
// generator for one active-low push-button.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   key_n_i   raw button, active-low, asynchronous to clk
//   press_o   one-cycle pulse on each debounced released->pressed transition
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_q, sync1_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Counter runs only while the synchronised level disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync1_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync1_q;
                // Pulse only when leaving the released (high) level.
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b1;
            sync1_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync0_q <= key_n_i;
            sync1_q <= sync0_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: lets a user enter operand A, operand B and carry-in in
// turn with one push-button, and presents them frozen on the adder bus.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   key_n     raw push-button, active-low
//   data_sw   operand value switches, sampled on a press
//   cin_sw    carry-in switch, sampled on the press that enters READY
//   operands  {cin, A, B} adder bus
//   valid     high while operands is complete
//   phase     current entry state for LEDs
// Build option OPERAND_SEQUENCER_RESULT_CAPTURE_EN adds sum_in/result: the
// adder result is latched on the cycle after READY is entered.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_n,
    input  logic [OPERAND_W-1:0] data_sw,
    input  logic                 cin_sw,
    output logic [BUS_W-1:0]     operands,
    output logic                 valid,
`ifdef OPERAND_SEQUENCER_RESULT_CAPTURE_EN
    input  logic [4:0]           sum_in,
    output logic [4:0]           result,
`endif
    output logic [1:0]           phase
);

    logic press;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_n),
        .press_o (press)
    );

    state_e           state_q, state_d;
    logic [BUS_W-1:0] operands_q, operands_d;
    logic             valid_q, valid_d;
    logic             enter_ready;

    always_comb begin
        state_d     = state_q;
        operands_d  = operands_q;
        valid_d     = valid_q;
        enter_ready = 1'b0;
        if (press) begin
            case (state_q)
                IDLE, READY: begin
                    state_d    = LOAD_A;
                    operands_d = '0;
                    valid_d    = 1'b0;
                end
                LOAD_A: begin
                    state_d                   = LOAD_B;
                    operands_d[A_MSB:A_LSB]   = data_sw;
                end
                LOAD_B: begin
                    state_d                   = READY;
                    operands_d[B_MSB:B_LSB]   = data_sw;
                    operands_d[CIN_BIT]       = cin_sw;
                    valid_d                   = 1'b1;
                    enter_ready               = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            operands_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            operands_q <= operands_d;
            valid_q    <= valid_d;
        end
    end

    assign operands = operands_q;
    assign valid    = valid_q;
    assign phase    = state_q;

`ifdef OPERAND_SEQUENCER_RESULT_CAPTURE_EN
    // Capture one cycle after READY entry so the adder has seen the new bus.
    logic       capture_q;
    logic [4:0] result_q, result_d;

    always_comb begin
        result_d = result_q;
        if (capture_q) begin
            result_d = sum_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_q <= 1'b0;
            result_q  <= '0;
        end else begin
            capture_q <= enter_ready;
            result_q  <= result_d;
        end
    end

    assign result = result_q;
`else
    logic unused_enter_ready;
    assign unused_enter_ready = enter_ready;
`endif

endmodule
